tile_scheduler: RTL
===================

Name: tile_scheduler

Overview:
Sequences the weight/input-feature tile controller across a full layer. Takes one layer descriptor (M×N×K tile counts, base addresses, strides) and issues one controller start per tile. For each start it presents the weight and IF buffer addresses and the accumulator first/last flags. After the last K tile of each output tile it runs a drain handshake with the output path. Sits between the host/config register block and the tile controller.

Parameters:
ADDR_W, 16, buffer address width; all address arithmetic wraps modulo 2^ADDR_W
CNT_W, 8, width of the tile-count config fields and internal loop counters
PERF_W, 32, width of the stall counter (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  scheduler idle and accepting a descriptor
cfg_m_tiles, cfg_n_tiles, cfg_k_tiles  in  CNT_W each  loop counts
cfg_w_base, cfg_if_base  in  ADDR_W each  base addresses
cfg_w_stride, cfg_if_stride  in  ADDR_W each  per-K-tile address increments
ctrl_ready  in  1  tile controller idle (level)
ctrl_done  in  1  one-cycle pulse: issued tile finished
ctrl_start  out  1  one-cycle start pulse to tile controller
w_addr, if_addr  out  ADDR_W  tile addresses, valid while ctrl_start=1
acc_clr  out  1  with ctrl_start: first K tile (k==0)
acc_last  out  1  with ctrl_start: last K tile (k==K-1)
drain_req  out  1  output-tile drain request (level)
drain_ack  in  1  drain complete
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: layer complete
perf_stall  out  PERF_W  stall cycle count (0 without the feature)

Behaviour:
- Reset: all outputs 0 except cfg_ready=1. State=IDLE. Counters, pointers and latched config are cleared. Reset mid-layer aborts immediately; no done pulse is produced.
- Loop order: m outer, n middle, k inner.
- Address values:
  - w_addr = w_base + (n·K + k)·w_stride
  - if_addr = if_base + (m·K + k)·if_stride
- Address generation is incremental with no multipliers:
  - w_ptr: loaded with w_base at each m start; += w_stride after every tile.
  - if_ptr: += if_stride after every tile.
  - if_row: captures if_ptr at each m start; if_ptr reloads if_row at each n start.
- FSM states and transitions:
  - IDLE: cfg_ready=1. A cycle with cfg_valid=1 latches all cfg fields.
    - Any count zero -> FIN.
    - Otherwise -> ISSUE.
  - ISSUE: if ctrl_ready=1, pulse ctrl_start for one cycle with w_addr, if_addr, acc_clr and acc_last, then -> WAIT. If ctrl_ready=0, hold in ISSUE with ctrl_start=0.
  - WAIT: on ctrl_done -> DRAIN if acc_last was set for the issued tile, else -> ADV. A ctrl_done outside WAIT is ignored.
  - DRAIN: drain_req=1 until a cycle with drain_ack=1. drain_req drops the following cycle, then -> ADV.
  - ADV (1 cycle): advance k/n/m counters and pointers. -> FIN if the final tile (m=M-1, n=N-1, k=K-1) was just completed, else -> ISSUE.
  - FIN: done=1 for one cycle -> IDLE.
- Latency: descriptor to first ctrl_start is 2 cycles when ctrl_ready=1. ADV adds one cycle between tiles.
- cfg_valid outside IDLE is ignored. cfg_ready=0 there.
- Count fields are unsigned; the maximum count is 2^CNT_W-1.
- ctrl_start and done are never asserted in the same cycle.

Optional Feature:
TILE_SCHED_PERF_EN
- Defined: perf_stall increments every cycle spent in ISSUE with ctrl_ready=0, or in DRAIN with drain_ack=0. It clears on reset and on descriptor acceptance, and saturates at all-ones.
- Undefined: perf_stall is tied to 0 and no counter logic exists.

Decomposition:
- Package tile_sched_pkg: state enum (IDLE, ISSUE, WAIT, DRAIN, ADV, FIN) and a layer descriptor packed struct.
- Sub-module tile_addr_gen: holds w_ptr, if_ptr and if_row. Inputs are load, next_k, next_n and next_m strobes; outputs are the two addresses.

Test Plan:
- M=N=K=1, w_base=0x010, if_base=0x020, ctrl_ready=1, ctrl_done 3 cycles after start, drain_ack 2 cycles later -> exactly one start with w=0x010, if=0x020, acc_clr=1, acc_last=1; one drain; done pulse; busy drops.
- M=2,N=2,K=3, w_base=0x100 stride 0x10, if_base=0x400 stride 0x20 -> 12 starts.
  - w sequence: 100,110,120,130,140,150, then repeats.
  - if sequence: 400,420,440, 400,420,440, 460,480,4A0, 460,480,4A0.
  - acc_clr on every 3rd start beginning with the 1st; exactly 4 drains.
- cfg_k_tiles=0 -> no ctrl_start and no drain_req; done pulses 2 cycles after acceptance.
- Hold ctrl_ready=0 for 5 cycles at the second tile -> ctrl_start delayed exactly 5 cycles. With TILE_SCHED_PERF_EN, perf_stall ≥5.
- Assert rst during DRAIN of a M=1,N=1,K=2 layer -> all outputs return to reset values asynchronously, no done pulse. A new descriptor afterwards runs from tile 0.
- Pulse cfg_valid with different fields while busy -> the running layer's addresses are unaffected.

Source files
------------

// File: rtl/tile_sched_pkg.sv
// Shared types for the layer tile scheduler: FSM state encoding and the
// latched layer descriptor.
package tile_sched_pkg;

  localparam int unsigned TS_ADDR_W = 16;
  localparam int unsigned TS_CNT_W  = 8;
  localparam int unsigned TS_PERF_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    ADV,
    FIN
  } state_t;

  typedef struct packed {
    logic [TS_CNT_W-1:0]  m_tiles;
    logic [TS_CNT_W-1:0]  n_tiles;
    logic [TS_CNT_W-1:0]  k_tiles;
    logic [TS_ADDR_W-1:0] w_base;
    logic [TS_ADDR_W-1:0] if_base;
    logic [TS_ADDR_W-1:0] w_stride;
    logic [TS_ADDR_W-1:0] if_stride;
  } desc_t;

  // An empty loop nest means the layer completes without issuing any tile.
  function automatic logic desc_empty(input desc_t d);
    return (d.m_tiles == '0) || (d.n_tiles == '0) || (d.k_tiles == '0);
  endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Bundle of config, tile-controller and drain signals around the scheduler.
// master = scheduler side, slave = host/controller/output-path side.
interface tile_scheduler_if
  import tile_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = TS_ADDR_W,
  parameter int unsigned CNT_W  = TS_CNT_W,
  parameter int unsigned PERF_W = TS_PERF_W
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_m_tiles;
  logic [CNT_W-1:0]  cfg_n_tiles;
  logic [CNT_W-1:0]  cfg_k_tiles;
  logic [ADDR_W-1:0] cfg_w_base;
  logic [ADDR_W-1:0] cfg_if_base;
  logic [ADDR_W-1:0] cfg_w_stride;
  logic [ADDR_W-1:0] cfg_if_stride;
  logic              ctrl_ready;
  logic              ctrl_done;
  logic              ctrl_start;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] if_addr;
  logic              acc_clr;
  logic              acc_last;
  logic              drain_req;
  logic              drain_ack;
  logic              busy;
  logic              done;
  logic [PERF_W-1:0] perf_stall;

  modport master (
    input  cfg_valid, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles,
           cfg_w_base, cfg_if_base, cfg_w_stride, cfg_if_stride,
           ctrl_ready, ctrl_done, drain_ack,
    output cfg_ready, ctrl_start, w_addr, if_addr, acc_clr, acc_last,
           drain_req, busy, done, perf_stall
  );

  modport slave (
    output cfg_valid, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles,
           cfg_w_base, cfg_if_base, cfg_w_stride, cfg_if_stride,
           ctrl_ready, ctrl_done, drain_ack,
    input  cfg_ready, ctrl_start, w_addr, if_addr, acc_clr, acc_last,
           drain_req, busy, done, perf_stall
  );

endinterface

// File: rtl/tile_addr_gen.sv
// Incremental weight / input-feature tile address generator (adders only).
module tile_addr_gen #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              next_k,
  input  logic              next_n,
  input  logic              next_m,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] if_base,
  input  logic [ADDR_W-1:0] w_stride,
  input  logic [ADDR_W-1:0] if_stride,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] if_addr
);

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] if_ptr;
  logic [ADDR_W-1:0] if_row;

  // if_row marks the first K tile of the current m row so each n pass replays it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr  <= '0;
      if_ptr <= '0;
      if_row <= '0;
    end else if (load) begin
      w_ptr  <= w_base;
      if_ptr <= if_base;
      if_row <= if_base;
    end else if (next_m) begin
      w_ptr  <= w_base;
      if_ptr <= if_ptr + if_stride;
      if_row <= if_ptr + if_stride;
    end else if (next_n) begin
      w_ptr  <= w_ptr + w_stride;
      if_ptr <= if_row;
    end else if (next_k) begin
      w_ptr  <= w_ptr + w_stride;
      if_ptr <= if_ptr + if_stride;
    end
  end

  assign w_addr  = w_ptr;
  assign if_addr = if_ptr;

endmodule

// File: rtl/tile_scheduler.sv
// Layer tile scheduler: walks M x N x K tiles (m outer, k inner), starts the
// tile controller per tile and drains each output tile. Optional stall
// counter enabled by defining TILE_SCHED_PERF_EN.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = TS_ADDR_W,
  parameter int unsigned CNT_W  = TS_CNT_W,
  parameter int unsigned PERF_W = TS_PERF_W
) (
  input logic              clk,
  input logic              rst,
  tile_scheduler_if.master bus
);

  state_t            state;
  state_t            state_nx;
  desc_t             desc_in;
  desc_t             cfg_q;
  logic [CNT_W-1:0]  m_cnt;
  logic [CNT_W-1:0]  n_cnt;
  logic [CNT_W-1:0]  k_cnt;
  logic              accept;
  logic              issue;
  logic              last_k;
  logic              last_n;
  logic              last_m;
  logic              step_k;
  logic              step_n;
  logic              step_m;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] if_ptr;
  logic              ctrl_start_q;
  logic              acc_clr_q;
  logic              acc_last_q;
  logic              done_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [ADDR_W-1:0] if_addr_q;

  assign desc_in = '{m_tiles:   bus.cfg_m_tiles,
                     n_tiles:   bus.cfg_n_tiles,
                     k_tiles:   bus.cfg_k_tiles,
                     w_base:    bus.cfg_w_base,
                     if_base:   bus.cfg_if_base,
                     w_stride:  bus.cfg_w_stride,
                     if_stride: bus.cfg_if_stride};

  assign accept = (state == IDLE) && bus.cfg_valid;
  assign issue  = (state == ISSUE) && bus.ctrl_ready;
  assign last_k = (k_cnt == cfg_q.k_tiles - CNT_W'(1));
  assign last_n = (n_cnt == cfg_q.n_tiles - CNT_W'(1));
  assign last_m = (m_cnt == cfg_q.m_tiles - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    step_k   = 1'b0;
    step_n   = 1'b0;
    step_m   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cfg_valid) state_nx = desc_empty(desc_in) ? FIN : ISSUE;
      end
      ISSUE: begin
        if (bus.ctrl_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (bus.ctrl_done) state_nx = last_k ? DRAIN : ADV;
      end
      DRAIN: begin
        if (bus.drain_ack) state_nx = ADV;
      end
      ADV: begin
        state_nx = ISSUE;
        if (!last_k)      step_k = 1'b1;
        else if (!last_n) step_n = 1'b1;
        else if (!last_m) step_m = 1'b1;
        else              state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q <= '0;
      m_cnt <= '0;
      n_cnt <= '0;
      k_cnt <= '0;
    end else if (accept) begin
      cfg_q <= desc_in;
      m_cnt <= '0;
      n_cnt <= '0;
      k_cnt <= '0;
    end else if (step_k) begin
      k_cnt <= k_cnt + CNT_W'(1);
    end else if (step_n) begin
      k_cnt <= '0;
      n_cnt <= n_cnt + CNT_W'(1);
    end else if (step_m) begin
      k_cnt <= '0;
      n_cnt <= '0;
      m_cnt <= m_cnt + CNT_W'(1);
    end
  end

  // Bases come straight from the config bus on the accept cycle so the
  // pointers are ready by the first ISSUE.
  tile_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .next_k   (step_k),
    .next_n   (step_n),
    .next_m   (step_m),
    .w_base   (accept ? bus.cfg_w_base  : cfg_q.w_base),
    .if_base  (accept ? bus.cfg_if_base : cfg_q.if_base),
    .w_stride (cfg_q.w_stride),
    .if_stride(cfg_q.if_stride),
    .w_addr   (w_ptr),
    .if_addr  (if_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_start_q <= 1'b0;
      acc_clr_q    <= 1'b0;
      acc_last_q   <= 1'b0;
      w_addr_q     <= '0;
      if_addr_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      ctrl_start_q <= issue;
      done_q       <= (state == FIN);
      if (issue) begin
        acc_clr_q  <= (k_cnt == '0);
        acc_last_q <= last_k;
        w_addr_q   <= w_ptr;
        if_addr_q  <= if_ptr;
      end else begin
        acc_clr_q  <= 1'b0;
        acc_last_q <= 1'b0;
        w_addr_q   <= '0;
        if_addr_q  <= '0;
      end
    end
  end

  assign bus.cfg_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.drain_req  = (state == DRAIN);
  assign bus.ctrl_start = ctrl_start_q;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.acc_last   = acc_last_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.if_addr    = if_addr_q;
  assign bus.done       = done_q;

`ifdef TILE_SCHED_PERF_EN
  logic [PERF_W-1:0] stall_q;
  logic              stall;

  assign stall = ((state == ISSUE) && !bus.ctrl_ready) ||
                 ((state == DRAIN) && !bus.drain_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         stall_q <= '0;
    else if (accept)                 stall_q <= '0;
    else if (stall && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
  end

  assign bus.perf_stall = stall_q;
`else
  assign bus.perf_stall = {PERF_W{1'b0}};
`endif

endmodule
